// File: rtl/regfile_pkg.sv
// Shared constants for the operand register file: active-low enable levels,
// default geometry and the bulk-clear FSM state encoding.
package regfile_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// Bulk-clear sequencer: walks every entry once, issuing one clear strobe per
// cycle, and holds busy high for exactly 2**ADDR_W cycles.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              clr_req_,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    clr_state_e        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clr_req_ == ENABLE_) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // Requests are ignored here: no restart, no extension.
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign clr_we   = (state_q == ST_CLEAR);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Operand register file: two combinational read ports, one byte-masked write
// port with optional bypass, optional hard-zero entry 0 and bulk clear.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic [ADDR_W-1:0]     ra_addr,
    output logic [DATA_W-1:0]     ra_data,
    input  logic [ADDR_W-1:0]     rb_addr,
    output logic [DATA_W-1:0]     rb_data,
    input  logic                  we_,
    input  logic [ADDR_W-1:0]     w_addr,
    input  logic [DATA_W-1:0]     w_data,
    input  logic [DATA_W/8-1:0]   w_be_,
    input  logic                  clr_req_,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] wr_merged;
    logic              wr_en;
    logic              wr_active;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    regfile_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .reset_   (reset_),
        .clr_req_ (clr_req_),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Write port is live only outside a clear; entry 0 may be hard-wired.
    assign wr_active = !busy && (we_ == ENABLE_);
    assign wr_en     = wr_active && !((ZERO_REG != 0) && (w_addr == '0));

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign wr_merged[gi*8 +: 8] = (w_be_[gi] == ENABLE_) ?
                                          w_data[gi*8 +: 8] :
                                          mem_q[w_addr][gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (clr_we) begin
                mem_q[clr_addr] <= '0;
            end
            if (wr_en) begin
                mem_q[w_addr] <= wr_merged;
            end
        end
    end

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    assign rd_addr[0] = ra_addr;
    assign rd_addr[1] = rb_addr;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                rd_data[gi] = mem_q[rd_addr[gi]];
                if (busy) begin
                    rd_data[gi] = '0;
                end else if ((ZERO_REG != 0) && (rd_addr[gi] == '0)) begin
                    rd_data[gi] = '0;
                end else if ((BYPASS != 0) && wr_active && (rd_addr[gi] == w_addr)) begin
                    rd_data[gi] = wr_merged;
                end
            end
        end
    endgenerate

    assign ra_data = rd_data[0];
    assign rb_data = rd_data[1];

endmodule
